// File: rtl/led_blink_multi.sv
// ----------------------------------------------------------------------------
// led_blink_multi
//
// Multi-LED pattern blinker driven by one shared prescaler.
// The prescaler runs at one of four half-periods, chosen from the board
// switches. Each time it wraps, the selected LED pattern advances.
// The available patterns are off, blink, chase and alternate.
// o_Tick exports the wrap strobe so other slow logic can use it.
//
// Parameters
//   g_NUM_LEDS   number of LED outputs (>= 2)
//   g_CNT_WIDTH  prescaler counter width
//   g_COUNT_0..3 prescaler period in clocks for rate select 0..3
//
// Ports
//   i_Clk       system clock
//   i_Rst       synchronous reset, active-high
//   i_Enable    1 = run, 0 = freeze all state and blank the LEDs
//   i_Rate_Sel  rate select, sampled on reset and on every prescaler wrap
//   i_Mode      00 off, 01 blink, 10 chase, 11 alternate
//   o_LED       registered LED drive, bit 0 = LED 1
//   o_Tick      registered one-cycle pulse at each prescaler wrap
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module led_blink_multi #(
    parameter int g_NUM_LEDS  = 4,
    parameter int g_CNT_WIDTH = 24,
    parameter int g_COUNT_0   = 1250000,
    parameter int g_COUNT_1   = 2500000,
    parameter int g_COUNT_2   = 6250000,
    parameter int g_COUNT_3   = 12500000
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic                  i_Enable,
    input  logic [1:0]            i_Rate_Sel,
    input  logic [1:0]            i_Mode,
    output logic [g_NUM_LEDS-1:0] o_LED,
    output logic                  o_Tick
);

    localparam longint CNT_RANGE = longint'(1) << g_CNT_WIDTH;

    // Bad parameter sets are rejected at elaboration rather than producing
    // a prescaler that can never wrap or wraps every cycle.
    generate
        if (g_NUM_LEDS < 2) begin : g_bad_leds
            $error("led_blink_multi: g_NUM_LEDS must be >= 2");
        end
        if (g_COUNT_0 < 2 || longint'(g_COUNT_0) >= CNT_RANGE) begin : g_bad_count_0
            $error("led_blink_multi: g_COUNT_0 out of range");
        end
        if (g_COUNT_1 < 2 || longint'(g_COUNT_1) >= CNT_RANGE) begin : g_bad_count_1
            $error("led_blink_multi: g_COUNT_1 out of range");
        end
        if (g_COUNT_2 < 2 || longint'(g_COUNT_2) >= CNT_RANGE) begin : g_bad_count_2
            $error("led_blink_multi: g_COUNT_2 out of range");
        end
        if (g_COUNT_3 < 2 || longint'(g_COUNT_3) >= CNT_RANGE) begin : g_bad_count_3
            $error("led_blink_multi: g_COUNT_3 out of range");
        end
    endgenerate

    localparam logic [g_CNT_WIDTH-1:0] LIMIT_0 = g_CNT_WIDTH'(g_COUNT_0 - 1);
    localparam logic [g_CNT_WIDTH-1:0] LIMIT_1 = g_CNT_WIDTH'(g_COUNT_1 - 1);
    localparam logic [g_CNT_WIDTH-1:0] LIMIT_2 = g_CNT_WIDTH'(g_COUNT_2 - 1);
    localparam logic [g_CNT_WIDTH-1:0] LIMIT_3 = g_CNT_WIDTH'(g_COUNT_3 - 1);

    // Alternate pattern starts as ...0101 (even-numbered bits lit).
    localparam logic [2*g_NUM_LEDS-1:0] ALT_WIDE = {g_NUM_LEDS{2'b01}};
    localparam logic [g_NUM_LEDS-1:0]   ALT_INIT = ALT_WIDE[g_NUM_LEDS-1:0];
    localparam logic [g_NUM_LEDS-1:0]   CHASE_INIT = g_NUM_LEDS'(1);

    logic [g_CNT_WIDTH-1:0] cnt;
    logic [1:0]             rate;
    logic [1:0]             prev_mode;
    logic                   phase;
    logic [g_NUM_LEDS-1:0]  chase;
    logic [g_NUM_LEDS-1:0]  alt;

    logic [g_CNT_WIDTH-1:0] limit;
    logic                   wrap;
    logic                   mode_changed;
    logic                   phase_nxt;
    logic [g_NUM_LEDS-1:0]  chase_nxt;
    logic [g_NUM_LEDS-1:0]  alt_nxt;
    logic [g_NUM_LEDS-1:0]  led_nxt;

    // The terminal count follows the latched rate, not the live switch.
    // A switch change therefore never cuts the running period short.
    always_comb begin
        limit = LIMIT_0;
        unique case (rate)
            2'd0:    limit = LIMIT_0;
            2'd1:    limit = LIMIT_1;
            2'd2:    limit = LIMIT_2;
            default: limit = LIMIT_3;
        endcase
    end

    assign wrap         = i_Enable && (cnt == limit);
    assign mode_changed = (i_Mode != prev_mode);

    // Pattern next-state. A mode change reinitialises the patterns and
    // overrides a coincident wrap, so no advance happens on that edge.
    // The LED mux looks at the next-state values.
    // As a result, o_LED updates on the same edge that o_Tick rises.
    always_comb begin
        phase_nxt = phase;
        chase_nxt = chase;
        alt_nxt   = alt;
        if (mode_changed) begin
            phase_nxt = 1'b0;
            chase_nxt = CHASE_INIT;
            alt_nxt   = ALT_INIT;
        end else if (wrap) begin
            phase_nxt = ~phase;
            chase_nxt = {chase[g_NUM_LEDS-2:0], chase[g_NUM_LEDS-1]};
            alt_nxt   = ~alt;
        end

        led_nxt = '0;
        unique case (i_Mode)
            2'b00:   led_nxt = '0;
            2'b01:   led_nxt = {g_NUM_LEDS{phase_nxt}};
            2'b10:   led_nxt = chase_nxt;
            default: led_nxt = alt_nxt;
        endcase
    end

    // Reset wins over everything. When disabled, the counter and latched rate
    // hold, and the outputs are blanked. Mode tracking keeps running so that
    // a switch flip while frozen still reinitialises the pattern.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            cnt       <= '0;
            rate      <= i_Rate_Sel;
            prev_mode <= i_Mode;
            phase     <= 1'b0;
            chase     <= CHASE_INIT;
            alt       <= ALT_INIT;
            o_Tick    <= 1'b0;
            o_LED     <= '0;
        end else begin
            prev_mode <= i_Mode;
            phase     <= phase_nxt;
            chase     <= chase_nxt;
            alt       <= alt_nxt;
            o_Tick    <= wrap;
            o_LED     <= i_Enable ? led_nxt : '0;
            if (i_Enable) begin
                if (wrap) begin
                    cnt  <= '0;
                    rate <= i_Rate_Sel;
                end else begin
                    cnt  <= cnt + 1'b1;
                end
            end
        end
    end

endmodule
